// File: rtl/debounce_pkg.sv
// Shared constants and parameter-derivation helpers for the switch debouncer bank.
package debounce_pkg;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_SIM_TICKS   = 2;
   localparam int DEF_DEBOUNCE_MS = 10;

   // Length of the stability window in clock cycles.
   function automatic int db_ticks(input int clk_hz, input int ms, input int sim, input int sim_ticks);
      return (sim != 0) ? sim_ticks : (clk_hz / 1000) * ms;
   endfunction

   // Counter must hold 0..ticks-1; never narrower than one bit.
   function automatic int cnt_width(input int ticks);
      return (ticks < 2) ? 1 : $clog2(ticks);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser chain, stability counter, debounced level and edge pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   DB_TICKS    = DEF_SIM_TICKS,
   parameter int   W           = 1,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_in,
   output logic sw_db,
   output logic sw_rise,
   output logic sw_fall,
   output logic upd
);

   localparam logic [W-1:0] LAST = W'(DB_TICKS - 1);

   logic [SYNC_STAGES-1:0] sync_sr;
   logic [W-1:0]           cnt;
   logic                   sync_last;

   assign sync_last = sync_sr[SYNC_STAGES-1];
   // Level has disagreed for the full window: commit on this edge.
   assign upd       = (sync_last != sw_db) && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_sr <= {SYNC_STAGES{RST_VAL}};
         sw_db   <= RST_VAL;
         cnt     <= '0;
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
      end else begin
         sync_sr <= {sync_sr[SYNC_STAGES-2:0], sw_in};
         sw_rise <= upd & sync_last;
         sw_fall <= upd & ~sync_last;
         if (upd) begin
            sw_db <= sync_last;
            cnt   <= '0;
         end else if (sync_last == sw_db) begin
            cnt   <= '0;
         end else begin
            cnt   <= cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch/button debouncer with per-channel rise/fall pulses and a shared change flag.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int              N_CH        = 16,
   parameter int              SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int              CLK_HZ      = 10_000_000,
   parameter int              DEBOUNCE_MS = DEF_DEBOUNCE_MS,
   parameter int              SIMULATION  = 0,
   parameter int              SIM_TICKS   = DEF_SIM_TICKS,
   parameter logic [N_CH-1:0] RST_VAL     = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] sw_in,
   output logic [N_CH-1:0] sw_db,
   output logic [N_CH-1:0] sw_rise,
   output logic [N_CH-1:0] sw_fall,
   output logic            any_change
);

   localparam int DB_TICKS = db_ticks(CLK_HZ, DEBOUNCE_MS, SIMULATION, SIM_TICKS);
   localparam int W        = cnt_width(DB_TICKS);

   if (DB_TICKS < 1) begin : g_bad_ticks
      $error("debounce_bank: debounce window must be at least one cycle");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_bank: synchroniser needs at least two stages");
   end

   logic [N_CH-1:0] upd;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_TICKS    (DB_TICKS),
         .W           (W),
         .RST_VAL     (RST_VAL[i])
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .sw_in   (sw_in[i]),
         .sw_db   (sw_db[i]),
         .sw_rise (sw_rise[i]),
         .sw_fall (sw_fall[i]),
         .upd     (upd[i])
      );
   end

   // Registered from the channels' commit condition so it lines up with the pulses.
   always_ff @(posedge clk) begin
      if (reset) any_change <= 1'b0;
      else       any_change <= |upd;
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: directed scenarios plus randomized bouncing inputs.
module tb_debounce_bank;

   localparam int         NC  = 4;
   localparam int         S   = 2;
   localparam int         T   = 4;
   localparam logic [3:0] RST = 4'h0;

   typedef struct packed {
      logic [3:0] db;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       any;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] sw_in;
   logic [3:0] sw_db, sw_rise, sw_fall;
   logic       any_change;

   int tests = 0;
   int fails = 0;

   exp_t       sb[$];
   logic [3:0] pipe[$];
   logic [3:0] m_db;
   int         run[NC];

   debounce_bank #(
      .N_CH        (NC),
      .SYNC_STAGES (S),
      .CLK_HZ      (10_000_000),
      .DEBOUNCE_MS (10),
      .SIMULATION  (1),
      .SIM_TICKS   (T),
      .RST_VAL     (RST)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_in      (sw_in),
      .sw_db      (sw_db),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .any_change (any_change)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: the level the block reports follows the synchronised input only
   // after that input has disagreed with it for T consecutive edges.
   task automatic model_edge(input logic r, input logic [3:0] v);
      exp_t       e;
      logic [3:0] s;
      e = '0;
      if (r || pipe.size() != S) begin
         pipe.delete();
         for (int k = 0; k < S; k++) pipe.push_back(RST);
         m_db = RST;
         for (int i = 0; i < NC; i++) run[i] = 0;
      end else begin
         s = pipe[S-1];
         for (int i = 0; i < NC; i++) begin
            if (s[i] !== m_db[i]) begin
               run[i]++;
               if (run[i] == T) begin
                  m_db[i]   = s[i];
                  e.rise[i] = s[i];
                  e.fall[i] = ~s[i];
                  e.any     = 1'b1;
                  run[i]    = 0;
               end
            end else begin
               run[i] = 0;
            end
         end
         pipe.push_front(v);
         void'(pipe.pop_back());
      end
      e.db = m_db;
      sb.push_back(e);
   endtask

   // Called just after a falling edge: drive inputs, predict, wait for the next falling edge.
   task automatic step(input logic r, input logic [3:0] v);
      reset = r;
      sw_in = v;
      model_edge(r, v);
      @(negedge clk);
   endtask

   task automatic dcheck(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      exp_t got;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {sw_db, sw_rise, sw_fall, any_change};
            tests++;
            if (got !== e) begin
               fails++;
               $display("FAIL sb @%0t: db=%h rise=%h fall=%h any=%b expected db=%h rise=%h fall=%h any=%b",
                        $time, got.db, got.rise, got.fall, got.any, e.db, e.rise, e.fall, e.any);
            end
         end
      end
   end

   initial begin : driver
      int         nr;
      int         hold[NC];
      logic [3:0] v;
      logic       r;

      reset = 1'b1;
      sw_in = 4'hF;
      @(negedge clk);

      // Reset with all inputs high, then release.
      for (int k = 0; k < 3; k++) step(1'b1, 4'hF);
      dcheck("rst_db", int'(sw_db), 0);
      dcheck("rst_any", int'(any_change), 0);
      for (int j = 1; j <= 8; j++) begin
         step(1'b0, 4'hF);
         if (j == 1) dcheck("release_no_pulse", int'(sw_rise), 0);
         if (j == 5) dcheck("release_db_e5", int'(sw_db), 0);
         if (j == 6) begin
            dcheck("release_db_e6", int'(sw_db), 15);
            dcheck("release_rise_e6", int'(sw_rise), 15);
            dcheck("release_any_e6", int'(any_change), 1);
         end
         if (j == 7) dcheck("release_any_e7", int'(any_change), 0);
      end

      // Clean rising step on ch0.
      for (int k = 0; k < 2; k++) step(1'b1, 4'h0);
      for (int k = 0; k < 8; k++) step(1'b0, 4'h0);
      for (int j = 1; j <= 8; j++) begin
         step(1'b0, 4'h1);
         if (j == 5) dcheck("step_db_e5", int'(sw_db[0]), 0);
         if (j == 6) begin
            dcheck("step_db_e6", int'(sw_db[0]), 1);
            dcheck("step_rise_e6", int'(sw_rise), 1);
         end
      end

      // Bouncing ch1: 3 high, 2 low, then held high.
      nr = 0;
      for (int k = 0; k < 3; k++) begin step(1'b0, 4'h3); nr += int'(sw_rise[1]); end
      for (int k = 0; k < 2; k++) begin step(1'b0, 4'h1); nr += int'(sw_rise[1]); end
      for (int j = 1; j <= 13; j++) begin
         step(1'b0, 4'h3);
         nr += int'(sw_rise[1]);
         if (j == 5) dcheck("bounce_db_e5", int'(sw_db[1]), 0);
         if (j == 6) dcheck("bounce_db_e6", int'(sw_db[1]), 1);
      end
      dcheck("bounce_rises", nr, 1);

      // Fall on ch2 from a debounced high.
      for (int k = 0; k < 8; k++) step(1'b0, 4'h7);
      for (int j = 1; j <= 8; j++) begin
         step(1'b0, 4'h3);
         if (j == 6) begin
            dcheck("fall_pulse", int'(sw_fall), 4);
            dcheck("fall_any", int'(any_change), 1);
            dcheck("fall_db", int'(sw_db[2]), 0);
         end
      end

      // Simultaneous: ch0 rises while ch3 falls.
      for (int k = 0; k < 8; k++) step(1'b0, 4'hB);
      for (int k = 0; k < 8; k++) step(1'b0, 4'hA);
      for (int j = 1; j <= 8; j++) begin
         step(1'b0, 4'h3);
         if (j == 6) begin
            dcheck("simul_rise", int'(sw_rise), 1);
            dcheck("simul_fall", int'(sw_fall), 8);
            dcheck("simul_any", int'(any_change), 1);
         end
         if (j == 7) dcheck("simul_any_once", int'(any_change), 0);
      end

      // Reset in the middle of a count on ch0.
      for (int k = 0; k < 8; k++) step(1'b0, 4'h0);
      step(1'b0, 4'h1);
      step(1'b0, 4'h1);
      step(1'b0, 4'h1);
      step(1'b1, 4'h1);
      dcheck("midrst_db", int'(sw_db), 0);
      for (int j = 1; j <= 8; j++) begin
         step(1'b0, 4'h1);
         if (j == 5) dcheck("midrst_db_e5", int'(sw_db[0]), 0);
         if (j == 6) begin
            dcheck("midrst_db_e6", int'(sw_db[0]), 1);
            dcheck("midrst_rise_e6", int'(sw_rise), 1);
         end
      end

      // Randomized bouncing with occasional reset.
      v = 4'h1;
      for (int i = 0; i < NC; i++) hold[i] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NC; i++) begin
            if (hold[i] == 0) begin
               v[i]    = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 9);
            end else begin
               hold[i]--;
            end
         end
         r = ($urandom_range(0, 99) == 0);
         step(r, v);
      end

      @(negedge clk);
      @(negedge clk);
      dcheck("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

endmodule
